chipbus_arbiter: RTL
====================

CHIPBUS_ARBITER -- requirements
Module: chipbus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: number of consecutive slots the CPU may lose to the blitter before it is forced a slot.
REQ-002 SHALL have port clk28m  input  1  28 MHz system clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk28m and active-high.
REQ-004 SHALL have port cck  input  1  colour clock enable; one slot spans one full cck period.
REQ-005 SHALL have port dma_req  input  1  fixed-slot DMA (disk, audio, sprite, bitplane) wants the current slot.
REQ-006 SHALL have port blit_req  input  1  blitter wants a slot.
REQ-007 SHALL have port blit_nasty  input  1  blitter-nasty mode; blitter always beats CPU.
REQ-008 SHALL have port cpu_req  input  1  CPU bridge access pending (rd|hwr|lwr).
REQ-009 SHALL have port bls  input  1  CPU slowdown request from bridge (CPU waiting on chip bus).
REQ-010 SHALL have port dma_grant, blit_grant, cpu_grant  output  1 each  slot owner, one-hot or all zero.
REQ-011 SHALL have port cpu_ack  output  1  one-cycle pulse: CPU access in its slot is complete.
REQ-012 SHALL have port cpu_wait  output  1  cpu_req & ~cpu_grant, registered.
REQ-013 SHALL have port owner  output  2  current slot state encoding (IDLE=0, DMA=1, BLIT=2, CPU=3).

Function
REQ-014 SHALL detect slot boundary as the cycle where registered cck is 0 and cck is 1 (rising edge).
REQ-015 SHALL decide the next owner only at a slot boundary; grants SHALL be registered and valid from the cycle after the boundary until the cycle after the next boundary.
REQ-016 SHALL use priority at each boundary: dma_req -> DMA; else blit_req and (blit_nasty or starve < STARVE_LIMIT or ~cpu_req) -> BLIT; else cpu_req -> CPU; else IDLE.
REQ-017 SHALL treat bls=1 as equivalent to starve reaching STARVE_LIMIT (CPU beats blitter) unless blit_nasty=1.
REQ-018 SHALL keep a starve counter (width clog2(STARVE_LIMIT+1)): +1 when a boundary grants BLIT while cpu_req=1; saturate at STARVE_LIMIT; clear on CPU grant or when cpu_req=0 at a boundary.
REQ-019 SHALL never preempt DMA: dma_req=1 wins even when starve = STARVE_LIMIT; starve SHALL hold (not increment) on DMA slots.
REQ-020 SHALL pulse cpu_ack for exactly one clk28m cycle at the cck falling edge inside a CPU-owned slot, only if cpu_req is still 1 then.
REQ-021 SHALL, if cpu_req drops mid CPU slot, keep cpu_grant to the slot end and suppress cpu_ack.
REQ-022 SHALL keep grants fixed mid-slot regardless of request changes; requests arriving mid-slot wait for the next boundary.
REQ-023 SHALL produce at most one grant high in any cycle; owner SHALL match the asserted grant.
REQ-024 SHALL give IDLE (all grants 0) when no request is present at the boundary.

Reset
REQ-025 SHALL, on reset=1 at any clock edge, force owner=IDLE, all grants=0, cpu_ack=0, cpu_wait=0, starve=0, cck edge register=0, effective next cycle.
REQ-026 SHALL, with reset asserted mid-slot, abandon that slot without cpu_ack; first grant after release only at the next detected boundary.

Structure
REQ-027 SHALL place the owner-state encoding and STARVE_LIMIT default in the shared chipset package.
REQ-028 SHALL implement cck edge detection (rise/fall strobes) as sub-module cck_edge; the arbiter FSM and starve counter stay in chipbus_arbiter.

Verification
REQ-029 SHALL verify: dma_req=blit_req=cpu_req=1 at boundary -> dma_grant=1 for the full slot, starve unchanged.
REQ-030 SHALL verify: blit_req and cpu_req held, blit_nasty=0, STARVE_LIMIT=3 -> slots BLIT,BLIT,BLIT,CPU,BLIT...; cpu_ack single pulse in the CPU slot.
REQ-031 SHALL verify: same stimulus with blit_nasty=1 -> BLIT every slot, cpu_wait=1 throughout, no cpu_ack.
REQ-032 SHALL verify: cpu_req alone, dropped before cck fall -> cpu_grant stays to slot end, cpu_ack never pulses.
REQ-033 SHALL verify: reset asserted 2 cycles into a CPU slot -> all outputs 0 next cycle; after release, no grant before next cck rise.
REQ-034 SHALL verify: bls=1 with blit_req=1, blit_nasty=0, starve=0 -> CPU granted at the next boundary.

Source files
------------

// File: rtl/chipbus_arbiter_pkg.sv
// Shared chipset definitions: slot-owner encoding and the default CPU starvation limit.
package chipbus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_DMA  = 2'd1,
        OWNER_BLIT = 2'd2,
        OWNER_CPU  = 2'd3
    } owner_e;

    localparam int STARVE_LIMIT_DEFAULT = 3;

endpackage

// File: rtl/chipbus_arbiter_cck_edge.sv
// Colour-clock edge detector: one-cycle rise/fall strobes derived from a registered copy of cck.
module cck_edge (
    input  logic clk28m,
    input  logic reset,
    input  logic cck,
    output logic rise,
    output logic fall
);

    logic cck_q;

    always_ff @(posedge clk28m) begin
        if (reset) begin
            cck_q <= 1'b0;
        end else begin
            cck_q <= cck;
        end
    end

    assign rise = cck & ~cck_q;
    assign fall = ~cck & cck_q;

endmodule

// File: rtl/chipbus_arbiter.sv
// Chip-bus slot arbiter: each colour-clock slot goes to DMA, blitter, CPU or nobody,
// with a starvation counter that periodically forces a CPU slot past a polite blitter.
module chipbus_arbiter
    import chipbus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic       clk28m,
    input  logic       reset,
    input  logic       cck,
    input  logic       dma_req,
    input  logic       blit_req,
    input  logic       blit_nasty,
    input  logic       cpu_req,
    input  logic       bls,
    output logic       dma_grant,
    output logic       blit_grant,
    output logic       cpu_grant,
    output logic       cpu_ack,
    output logic       cpu_wait,
    output logic [1:0] owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic          slot_start;
    logic          cck_fall;
    owner_e        state;
    owner_e        next_owner;
    logic [SW-1:0] starve;
    logic          cpu_favoured;
    logic          blit_wins;

    cck_edge u_cck_edge (
        .clk28m (clk28m),
        .reset  (reset),
        .cck    (cck),
        .rise   (slot_start),
        .fall   (cck_fall)
    );

    // bls lets a waiting CPU jump the queue early, but never against a nasty blitter.
    always_comb begin
        cpu_favoured = ~blit_nasty & ((starve >= STARVE_MAX) | bls);
        blit_wins    = blit_req & (~cpu_favoured | ~cpu_req);
        next_owner   = OWNER_IDLE;
        if (dma_req) begin
            next_owner = OWNER_DMA;
        end else if (blit_wins) begin
            next_owner = OWNER_BLIT;
        end else if (cpu_req) begin
            next_owner = OWNER_CPU;
        end
    end

    always_ff @(posedge clk28m) begin
        if (reset) begin
            state      <= OWNER_IDLE;
            dma_grant  <= 1'b0;
            blit_grant <= 1'b0;
            cpu_grant  <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_wait   <= 1'b0;
            starve     <= '0;
        end else begin
            cpu_wait <= cpu_req & ~cpu_grant;
            cpu_ack  <= cck_fall & (state == OWNER_CPU) & cpu_req;
            if (slot_start) begin
                state      <= next_owner;
                dma_grant  <= (next_owner == OWNER_DMA);
                blit_grant <= (next_owner == OWNER_BLIT);
                cpu_grant  <= (next_owner == OWNER_CPU);
                // DMA slots are invisible to the starvation count; it neither grows nor clears.
                if (next_owner != OWNER_DMA) begin
                    if ((next_owner == OWNER_CPU) || !cpu_req) begin
                        starve <= '0;
                    end else if ((next_owner == OWNER_BLIT) && (starve != STARVE_MAX)) begin
                        starve <= starve + 1'b1;
                    end
                end
            end
        end
    end

    assign owner = state;

endmodule
